pip_hazard_ctrl: RTL and testbench

//  Producer side of the pipeline-register control interface: generates the pip_en / discard

---
 rtl/pip_hazard_ctrl_pkg.sv | 36 +++
 rtl/pip_hazard_ctrl_if.sv | 74 +++++++
 rtl/pip_hazard_ctrl_fwd_unit.sv | 38 +++
 rtl/pip_hazard_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pip_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pip_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pip_hazard_ctrl_pkg
//   Shared types and encodings for the pipeline hazard controller:
//   register-address and forward-select types, the EX operand source
//   encodings, the RUN/WAIT state encoding, and the forwarding hit test
//   used by every forwarding unit.
// -----------------------------------------------------------------------------
package pip_hazard_ctrl_pkg;

  typedef logic [4:0] reg_ad_t;
  typedef logic [1:0] fwd_sel_t;

  // EX operand source encodings
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  localparam reg_ad_t REG_X0 = 5'd0;

  // Memory-stall sequencer states
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } hz_state_e;

  // A later stage can supply an EX operand when the operand is really read,
  // the later stage writes back, the addresses match, and the register is
  // not x0 (x0 is hard-wired to zero and must always come from the regfile).
  function automatic logic fwd_hit(input logic    rs_read,
                                   input reg_ad_t rs_ad,
                                   input logic    src_en,
                                   input reg_ad_t src_ad);
    return rs_read & src_en & (src_ad == rs_ad) & (rs_ad != REG_X0);
  endfunction

endpackage

// File: rtl/pip_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pip_hazard_ctrl_if
//   Bundle between the pipeline and the hazard controller.
//   Pipeline -> controller : decode, EX, MEM and WB stage control fields.
//   Controller -> pipeline : pc_en, en/discard pair per pipeline register,
//                            EX forwarding selects, stall/flush perf counters.
//   master : pipeline side (drives stage fields)
//   slave  : hazard controller side
// -----------------------------------------------------------------------------
interface pip_hazard_ctrl_if
  import pip_hazard_ctrl_pkg::*;
#(
  parameter int PERF_W = 32
);

  // decode stage
  reg_ad_t     id_rs1_ad;
  reg_ad_t     id_rs2_ad;
  logic        id_rs1_read;
  logic        id_rs2_read;
  // EX stage
  reg_ad_t     ex_rs1_ad;
  reg_ad_t     ex_rs2_ad;
  logic        ex_rs1_read;
  logic        ex_rs2_read;
  reg_ad_t     ex_rd_ad;
  logic        ex_rdEn;
  logic        ex_DMread;
  logic        ex_branch_comm;
  logic        ex_branch_taken;
  // MEM stage
  logic        mem_DM_access;
  reg_ad_t     mem_rd_ad;
  logic        mem_rdEn;
  // WB stage
  reg_ad_t     wb_rd_ad;
  logic        wb_rdEn;

  // controls back to the pipeline
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_discard;
  logic        id_ex_en;
  logic        id_ex_discard;
  logic        ex_mem_en;
  logic        ex_mem_discard;
  logic        mem_wb_en;
  logic        mem_wb_discard;
  fwd_sel_t    fwd_a_sel;
  fwd_sel_t    fwd_b_sel;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;

  modport master (
    output id_rs1_ad, id_rs2_ad, id_rs1_read, id_rs2_read,
    output ex_rs1_ad, ex_rs2_ad, ex_rs1_read, ex_rs2_read,
    output ex_rd_ad, ex_rdEn, ex_DMread, ex_branch_comm, ex_branch_taken,
    output mem_DM_access, mem_rd_ad, mem_rdEn, wb_rd_ad, wb_rdEn,
    input  pc_en, if_id_en, if_id_discard, id_ex_en, id_ex_discard,
    input  ex_mem_en, ex_mem_discard, mem_wb_en, mem_wb_discard,
    input  fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1_ad, id_rs2_ad, id_rs1_read, id_rs2_read,
    input  ex_rs1_ad, ex_rs2_ad, ex_rs1_read, ex_rs2_read,
    input  ex_rd_ad, ex_rdEn, ex_DMread, ex_branch_comm, ex_branch_taken,
    input  mem_DM_access, mem_rd_ad, mem_rdEn, wb_rd_ad, wb_rdEn,
    output pc_en, if_id_en, if_id_discard, id_ex_en, id_ex_discard,
    output ex_mem_en, ex_mem_discard, mem_wb_en, mem_wb_discard,
    output fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pip_hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// pip_fwd_unit
//   Combinational EX operand forwarding select for one operand.
//   Ports:
//     rs_ad, rs_read        EX-stage source address / read flag
//     mem_rd_ad, mem_rd_en  MEM-stage destination / write enable
//     wb_rd_ad, wb_rd_en    WB-stage destination / write enable
//     fwd_sel               FWD_MEM, FWD_WB or FWD_RF
// -----------------------------------------------------------------------------
module pip_fwd_unit
  import pip_hazard_ctrl_pkg::*;
(
  input  reg_ad_t  rs_ad,
  input  logic     rs_read,
  input  reg_ad_t  mem_rd_ad,
  input  logic     mem_rd_en,
  input  reg_ad_t  wb_rd_ad,
  input  logic     wb_rd_en,
  output fwd_sel_t fwd_sel
);

  logic hit_mem_s;
  logic hit_wb_s;

  // Select the youngest producer: MEM holds a newer value than WB.
  always_comb begin
    hit_mem_s = fwd_hit(rs_read, rs_ad, mem_rd_en, mem_rd_ad);
    hit_wb_s  = fwd_hit(rs_read, rs_ad, wb_rd_en, wb_rd_ad);
    if (hit_mem_s) begin
      fwd_sel = FWD_MEM;
    end else if (hit_wb_s) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pip_hazard_ctrl
//   Pipeline hazard controller. Drives the en/discard pair of every pipeline
//   register, the PC enable and the EX forwarding selects, handling load-use
//   stalls, taken-branch flushes and multi-cycle data-memory waits.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; while high every register is
//          enabled with discard set so that bubbles are loaded everywhere
//     hz   pip_hazard_ctrl_if.slave (stage fields in, controls/counters out)
//   Control outputs are combinational from state and inputs; the RUN/WAIT
//   sequencer, the wait counter and the perf counters are registered.
// -----------------------------------------------------------------------------
module pip_hazard_ctrl
  import pip_hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 4,
  parameter int PERF_W   = 32
)(
  input  logic             clk,
  input  logic             rst,
  pip_hazard_ctrl_if.slave hz
);

  localparam bit MEM_WAIT_EN = (MEM_WAIT > 0);
  // The triggering cycle is itself the first stall cycle, so the counter
  // loads MEM_WAIT-1 and the cycle where it reads zero is the release.
  localparam logic [CNT_W-1:0]  WAIT_LOAD = (MEM_WAIT > 0) ? CNT_W'(MEM_WAIT - 1)
                                                            : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_ZERO = {PERF_W{1'b0}};
  localparam logic [PERF_W-1:0] PERF_ONE  = {{(PERF_W-1){1'b0}}, 1'b1};
  localparam logic [PERF_W-1:0] PERF_MAX  = {PERF_W{1'b1}};

  hz_state_e         state_r;
  hz_state_e         state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nx_s;
  logic [PERF_W-1:0] stall_cnt_r;
  logic [PERF_W-1:0] flush_cnt_r;

  fwd_sel_t fwd_a_s;
  fwd_sel_t fwd_b_s;

  logic mem_stall_s;
  logic flush_s;
  logic load_use_s;
  logic stall_inc_s;
  logic flush_inc_s;

  logic     pc_en_s;
  logic     if_id_en_s;
  logic     if_id_discard_s;
  logic     id_ex_en_s;
  logic     id_ex_discard_s;
  logic     ex_mem_en_s;
  logic     ex_mem_discard_s;
  logic     mem_wb_en_s;
  logic     mem_wb_discard_s;
  fwd_sel_t fwd_a_sel_s;
  fwd_sel_t fwd_b_sel_s;

  pip_fwd_unit u_fwd_a (
    .rs_ad     (hz.ex_rs1_ad),
    .rs_read   (hz.ex_rs1_read),
    .mem_rd_ad (hz.mem_rd_ad),
    .mem_rd_en (hz.mem_rdEn),
    .wb_rd_ad  (hz.wb_rd_ad),
    .wb_rd_en  (hz.wb_rdEn),
    .fwd_sel   (fwd_a_s)
  );

  pip_fwd_unit u_fwd_b (
    .rs_ad     (hz.ex_rs2_ad),
    .rs_read   (hz.ex_rs2_read),
    .mem_rd_ad (hz.mem_rd_ad),
    .mem_rd_en (hz.mem_rdEn),
    .wb_rd_ad  (hz.wb_rd_ad),
    .wb_rd_en  (hz.wb_rdEn),
    .fwd_sel   (fwd_b_s)
  );

  // Raw hazard conditions from the EX and decode stage fields.
  always_comb begin
    flush_s    = hz.ex_branch_comm & hz.ex_branch_taken;
    load_use_s = hz.ex_DMread & hz.ex_rdEn & (hz.ex_rd_ad != REG_X0) &
                 ((hz.id_rs1_read & (hz.id_rs1_ad == hz.ex_rd_ad)) |
                  (hz.id_rs2_read & (hz.id_rs2_ad == hz.ex_rd_ad)));
  end

  // Memory-wait sequencer next state and the stall decision for this cycle.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    mem_stall_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (MEM_WAIT_EN && hz.mem_DM_access) begin
          mem_stall_s = 1'b1;
          state_nx_s  = ST_WAIT;
          cnt_nx_s    = WAIT_LOAD;
        end else begin
          state_nx_s  = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (cnt_r != CNT_ZERO) begin
          mem_stall_s = 1'b1;
          cnt_nx_s    = cnt_r - CNT_ONE;
        end else begin
          // release cycle: the same access is still visible but must not re-arm
          state_nx_s  = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_RUN;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
  end

  // Pipeline register controls: reset > memory stall > flush > load-use > run.
  always_comb begin
    pc_en_s          = 1'b1;
    if_id_en_s       = 1'b1;
    if_id_discard_s  = 1'b0;
    id_ex_en_s       = 1'b1;
    id_ex_discard_s  = 1'b0;
    ex_mem_en_s      = 1'b1;
    ex_mem_discard_s = 1'b0;
    mem_wb_en_s      = 1'b1;
    mem_wb_discard_s = 1'b0;
    fwd_a_sel_s      = fwd_a_s;
    fwd_b_sel_s      = fwd_b_s;
    flush_inc_s      = 1'b0;
    if (rst) begin
      // registers without reset get loaded with bubbles
      pc_en_s          = 1'b0;
      if_id_discard_s  = 1'b1;
      id_ex_discard_s  = 1'b1;
      ex_mem_discard_s = 1'b1;
      mem_wb_discard_s = 1'b1;
      fwd_a_sel_s      = FWD_RF;
      fwd_b_sel_s      = FWD_RF;
    end else if (mem_stall_s) begin
      // freeze everything up to EX/MEM; feed a bubble into WB
      pc_en_s          = 1'b0;
      if_id_en_s       = 1'b0;
      id_ex_en_s       = 1'b0;
      ex_mem_en_s      = 1'b0;
      mem_wb_discard_s = 1'b1;
    end else if (flush_s) begin
      if_id_discard_s  = 1'b1;
      id_ex_discard_s  = 1'b1;
      flush_inc_s      = 1'b1;
    end else if (load_use_s) begin
      // hold fetch/decode one cycle; a bubble enters EX behind the load
      pc_en_s          = 1'b0;
      if_id_en_s       = 1'b0;
      id_ex_discard_s  = 1'b1;
    end else begin
      pc_en_s          = 1'b1;
    end
    stall_inc_s = ~rst & ~pc_en_s;
  end

  // Sequencer state and wait counter; reset abandons any pending wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Saturating stall and flush performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= PERF_ZERO;
      flush_cnt_r <= PERF_ZERO;
    end else begin
      if (stall_inc_s && (stall_cnt_r != PERF_MAX)) begin
        stall_cnt_r <= stall_cnt_r + PERF_ONE;
      end
      if (flush_inc_s && (flush_cnt_r != PERF_MAX)) begin
        flush_cnt_r <= flush_cnt_r + PERF_ONE;
      end
    end
  end

  assign hz.pc_en          = pc_en_s;
  assign hz.if_id_en       = if_id_en_s;
  assign hz.if_id_discard  = if_id_discard_s;
  assign hz.id_ex_en       = id_ex_en_s;
  assign hz.id_ex_discard  = id_ex_discard_s;
  assign hz.ex_mem_en      = ex_mem_en_s;
  assign hz.ex_mem_discard = ex_mem_discard_s;
  assign hz.mem_wb_en      = mem_wb_en_s;
  assign hz.mem_wb_discard = mem_wb_discard_s;
  assign hz.fwd_a_sel      = fwd_a_sel_s;
  assign hz.fwd_b_sel      = fwd_b_sel_s;
  assign hz.stall_cnt      = stall_cnt_r;
  assign hz.flush_cnt      = flush_cnt_r;

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pip_hazard_ctrl
//   Scoreboard bench for pip_hazard_ctrl. DUT A: MEM_WAIT=3, PERF_W=32.
//   DUT B: MEM_WAIT=4, PERF_W=4 (reset during a wait, counter saturation).
//   Each vector pushes its expected outputs when inputs are driven; the
//   entry is popped and compared on the following falling edge.
//   Control word bit order: pc_en, if_id_en, if_id_discard, id_ex_en,
//   id_ex_discard, ex_mem_en, ex_mem_discard, mem_wb_en, mem_wb_discard.
// -----------------------------------------------------------------------------
module tb_pip_hazard_ctrl;
  import pip_hazard_ctrl_pkg::*;

  localparam logic [8:0] C_RST  = 9'b0_11_11_11_11;
  localparam logic [8:0] C_IDLE = 9'b1_10_10_10_10;
  localparam logic [8:0] C_MST  = 9'b0_00_00_00_11;
  localparam logic [8:0] C_LU   = 9'b0_00_11_10_10;
  localparam logic [8:0] C_FL   = 9'b1_11_11_10_10;

  typedef struct packed {
    logic [8:0]  ctl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] fc;
  } obs_t;

  typedef struct {
    int          sel;
    obs_t        v;
    bit          cnt_ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [31:0] m_sc[2];
  logic [31:0] m_fc[2];
  logic [31:0] m_max[2];
  obs_t obs_a;
  obs_t obs_b;

  pip_hazard_ctrl_if #(.PERF_W(32)) ifa ();
  pip_hazard_ctrl_if #(.PERF_W(4))  ifb ();

  pip_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(4), .PERF_W(32)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .hz  (ifa.slave)
  );

  pip_hazard_ctrl #(.MEM_WAIT(4), .CNT_W(4), .PERF_W(4)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .hz  (ifb.slave)
  );

  always #5 clk = ~clk;

  assign obs_a = {ifa.pc_en, ifa.if_id_en, ifa.if_id_discard, ifa.id_ex_en, ifa.id_ex_discard,
                  ifa.ex_mem_en, ifa.ex_mem_discard, ifa.mem_wb_en, ifa.mem_wb_discard,
                  ifa.fwd_a_sel, ifa.fwd_b_sel, ifa.stall_cnt, ifa.flush_cnt};
  assign obs_b = {ifb.pc_en, ifb.if_id_en, ifb.if_id_discard, ifb.id_ex_en, ifb.id_ex_discard,
                  ifb.ex_mem_en, ifb.ex_mem_discard, ifb.mem_wb_en, ifb.mem_wb_discard,
                  ifb.fwd_a_sel, ifb.fwd_b_sel, 28'd0, ifb.stall_cnt, 28'd0, ifb.flush_cnt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_a();
    ifa.id_rs1_ad = 5'd0;  ifa.id_rs2_ad = 5'd0;  ifa.id_rs1_read = 1'b0; ifa.id_rs2_read = 1'b0;
    ifa.ex_rs1_ad = 5'd0;  ifa.ex_rs2_ad = 5'd0;  ifa.ex_rs1_read = 1'b0; ifa.ex_rs2_read = 1'b0;
    ifa.ex_rd_ad  = 5'd0;  ifa.ex_rdEn = 1'b0;    ifa.ex_DMread = 1'b0;
    ifa.ex_branch_comm = 1'b0; ifa.ex_branch_taken = 1'b0;
    ifa.mem_DM_access = 1'b0; ifa.mem_rd_ad = 5'd0; ifa.mem_rdEn = 1'b0;
    ifa.wb_rd_ad = 5'd0;   ifa.wb_rdEn = 1'b0;
  endtask

  task automatic clr_b();
    ifb.id_rs1_ad = 5'd0;  ifb.id_rs2_ad = 5'd0;  ifb.id_rs1_read = 1'b0; ifb.id_rs2_read = 1'b0;
    ifb.ex_rs1_ad = 5'd0;  ifb.ex_rs2_ad = 5'd0;  ifb.ex_rs1_read = 1'b0; ifb.ex_rs2_read = 1'b0;
    ifb.ex_rd_ad  = 5'd0;  ifb.ex_rdEn = 1'b0;    ifb.ex_DMread = 1'b0;
    ifb.ex_branch_comm = 1'b0; ifb.ex_branch_taken = 1'b0;
    ifb.mem_DM_access = 1'b0; ifb.mem_rd_ad = 5'd0; ifb.mem_rdEn = 1'b0;
    ifb.wb_rd_ad = 5'd0;   ifb.wb_rdEn = 1'b0;
  endtask

  // Push the expected outputs for the inputs just driven, advance the counter
  // model, then pop and compare on the falling edge.
  task automatic step(input int sel, input string tag, input logic [8:0] ctl,
                      input logic [1:0] fa, input logic [1:0] fb, input bit cnt_ok);
    exp_t e;
    obs_t o;
    logic r;
    r = (sel == 0) ? rst_a : rst_b;
    e.sel    = sel;
    e.v      = {ctl, fa, fb, m_sc[sel], m_fc[sel]};
    e.cnt_ok = cnt_ok;
    exp_q.push_back(e);
    if (r) begin
      m_sc[sel] = 32'd0;
      m_fc[sel] = 32'd0;
    end else begin
      if (!ctl[8] && m_sc[sel] != m_max[sel]) m_sc[sel] = m_sc[sel] + 32'd1;
      if (ctl[8] && ctl[6] && m_fc[sel] != m_max[sel]) m_fc[sel] = m_fc[sel] + 32'd1;
    end
    @(negedge clk);
    e = exp_q.pop_front();
    o = (e.sel == 0) ? obs_a : obs_b;
    check({tag, ".ctl"}, 32'(o.ctl), 32'(e.v.ctl));
    check({tag, ".fwd_a"}, 32'(o.fa), 32'(e.v.fa));
    check({tag, ".fwd_b"}, 32'(o.fb), 32'(e.v.fb));
    if (e.cnt_ok) begin
      check({tag, ".stall_cnt"}, o.sc, e.v.sc);
      check({tag, ".flush_cnt"}, o.fc, e.v.fc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_sc[0] = 32'd0; m_fc[0] = 32'd0; m_max[0] = 32'hFFFF_FFFF;
    m_sc[1] = 32'd0; m_fc[1] = 32'd0; m_max[1] = 32'd15;
    rst_a = 1'b1;
    rst_b = 1'b1;
    clr_a();
    clr_b();

    // ---------------- DUT A: reset ----------------
    step(0, "rst0", C_RST, FWD_RF, FWD_RF, 1'b0);
    ifa.ex_rs1_ad = 5'd7; ifa.ex_rs1_read = 1'b1; ifa.mem_rd_ad = 5'd7; ifa.mem_rdEn = 1'b1;
    step(0, "rst1", C_RST, FWD_RF, FWD_RF, 1'b1);
    rst_a = 1'b0;
    clr_a();
    step(0, "idle0", C_IDLE, FWD_RF, FWD_RF, 1'b1);

    // ---------------- load-use ----------------
    ifa.ex_DMread = 1'b1; ifa.ex_rdEn = 1'b1; ifa.ex_rd_ad = 5'd5;
    ifa.id_rs1_read = 1'b1; ifa.id_rs1_ad = 5'd5;
    step(0, "lu", C_LU, FWD_RF, FWD_RF, 1'b1);
    clr_a();
    ifa.ex_rs1_read = 1'b1; ifa.ex_rs1_ad = 5'd5; ifa.wb_rd_ad = 5'd5; ifa.wb_rdEn = 1'b1;
    step(0, "lu_next", C_IDLE, FWD_WB, FWD_RF, 1'b1);
    clr_a();
    ifa.ex_DMread = 1'b1; ifa.ex_rdEn = 1'b1; ifa.ex_rd_ad = 5'd0;
    ifa.id_rs1_read = 1'b1; ifa.id_rs1_ad = 5'd0;
    step(0, "lu_x0", C_IDLE, FWD_RF, FWD_RF, 1'b1);
    ifa.ex_rd_ad = 5'd9; ifa.id_rs2_ad = 5'd9; ifa.id_rs2_read = 1'b0;
    step(0, "lu_noread", C_IDLE, FWD_RF, FWD_RF, 1'b1);
    ifa.id_rs2_read = 1'b1;
    step(0, "lu_rs2", C_LU, FWD_RF, FWD_RF, 1'b1);
    ifa.ex_DMread = 1'b0;
    step(0, "lu_alu", C_IDLE, FWD_RF, FWD_RF, 1'b1);

    // ---------------- branch flush ----------------
    clr_a();
    ifa.ex_DMread = 1'b1; ifa.ex_rdEn = 1'b1; ifa.ex_rd_ad = 5'd6;
    ifa.id_rs2_read = 1'b1; ifa.id_rs2_ad = 5'd6;
    ifa.ex_branch_comm = 1'b1; ifa.ex_branch_taken = 1'b1;
    step(0, "br_lu", C_FL, FWD_RF, FWD_RF, 1'b1);
    clr_a();
    ifa.ex_branch_comm = 1'b1;
    step(0, "br_nt", C_IDLE, FWD_RF, FWD_RF, 1'b1);
    ifa.ex_branch_comm = 1'b0; ifa.ex_branch_taken = 1'b1;
    step(0, "br_nc", C_IDLE, FWD_RF, FWD_RF, 1'b1);

    // ---------------- memory wait, branch held during the stall ----------------
    clr_a();
    ifa.mem_DM_access = 1'b1; ifa.ex_branch_comm = 1'b1; ifa.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) step(0, "mw_st", C_MST, FWD_RF, FWD_RF, 1'b1);
    step(0, "mw_rel", C_FL, FWD_RF, FWD_RF, 1'b1);
    clr_a();
    step(0, "mw_idle", C_IDLE, FWD_RF, FWD_RF, 1'b1);

    // ---------------- memory wait, load-use held during the stall ----------------
    ifa.mem_DM_access = 1'b1;
    ifa.ex_DMread = 1'b1; ifa.ex_rdEn = 1'b1; ifa.ex_rd_ad = 5'd3;
    ifa.id_rs1_read = 1'b1; ifa.id_rs1_ad = 5'd3;
    for (int i = 0; i < 3; i++) step(0, "mw2_st", C_MST, FWD_RF, FWD_RF, 1'b1);
    step(0, "mw2_rel", C_LU, FWD_RF, FWD_RF, 1'b1);
    clr_a();
    step(0, "mw2_idle", C_IDLE, FWD_RF, FWD_RF, 1'b1);

    // ---------------- forwarding ----------------
    ifa.mem_rd_ad = 5'd7; ifa.mem_rdEn = 1'b1; ifa.wb_rd_ad = 5'd7; ifa.wb_rdEn = 1'b1;
    ifa.ex_rs2_ad = 5'd7; ifa.ex_rs2_read = 1'b1;
    step(0, "fwd_mem", C_IDLE, FWD_RF, FWD_MEM, 1'b1);
    ifa.mem_rd_ad = 5'd0; ifa.wb_rd_ad = 5'd0; ifa.ex_rs2_ad = 5'd0;
    step(0, "fwd_x0", C_IDLE, FWD_RF, FWD_RF, 1'b1);
    ifa.mem_rd_ad = 5'd7; ifa.wb_rd_ad = 5'd7; ifa.ex_rs2_ad = 5'd7; ifa.mem_rdEn = 1'b0;
    step(0, "fwd_wb", C_IDLE, FWD_RF, FWD_WB, 1'b1);
    ifa.ex_rs2_read = 1'b0;
    step(0, "fwd_noread", C_IDLE, FWD_RF, FWD_RF, 1'b1);
    ifa.mem_rd_ad = 5'd3; ifa.mem_rdEn = 1'b1; ifa.wb_rd_ad = 5'd4; ifa.wb_rdEn = 1'b1;
    ifa.ex_rs1_ad = 5'd3; ifa.ex_rs1_read = 1'b1; ifa.ex_rs2_ad = 5'd4; ifa.ex_rs2_read = 1'b1;
    step(0, "fwd_ab", C_IDLE, FWD_MEM, FWD_WB, 1'b1);
    clr_a();
    step(0, "a_end", C_IDLE, FWD_RF, FWD_RF, 1'b1);

    // ---------------- DUT B: reset during the second wait cycle ----------------
    step(1, "b_rst", C_RST, FWD_RF, FWD_RF, 1'b1);
    rst_b = 1'b0;
    ifb.mem_DM_access = 1'b1;
    step(1, "b_st1", C_MST, FWD_RF, FWD_RF, 1'b1);
    rst_b = 1'b1;
    step(1, "b_rst_mid", C_RST, FWD_RF, FWD_RF, 1'b1);
    rst_b = 1'b0;
    ifb.mem_DM_access = 1'b0;
    step(1, "b_after0", C_IDLE, FWD_RF, FWD_RF, 1'b1);
    step(1, "b_after1", C_IDLE, FWD_RF, FWD_RF, 1'b1);

    // ---------------- DUT B: 16 stall cycles into a 4-bit counter ----------------
    for (int k = 0; k < 4; k++) begin
      ifb.mem_DM_access = 1'b1;
      for (int i = 0; i < 4; i++) step(1, "b_sat_st", C_MST, FWD_RF, FWD_RF, 1'b1);
      step(1, "b_sat_rel", C_IDLE, FWD_RF, FWD_RF, 1'b1);
      ifb.mem_DM_access = 1'b0;
      step(1, "b_sat_gap", C_IDLE, FWD_RF, FWD_RF, 1'b1);
    end
    step(1, "b_end", C_IDLE, FWD_RF, FWD_RF, 1'b1);
    check("b_sat_final", {28'd0, ifb.stall_cnt}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
